unified_mem_arbiter: RTL

- Shares one single-port unified instruction/data memory between the fetch stage (F) and the memory stage (M) of the pipelined MIPS core.
- Arbitrates the two requesters and sequences each fixed-latency memory access.
- Generates stall signals that are OR-ed into the stallF and stallD/stallM pipeline controls.
- Sits between the datapath and the memory, beside the hazard unit.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/unified_mem_arbiter_lat_counter.sv | 34 +++
 rtl/unified_mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
//   arb_state_t : arbiter FSM states
//   GRANT_IF/D  : encoding of the last_grant flag (0 = fetch, 1 = data)
//   CNT_W       : width of the access latency counter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_D  = 1'b1;

   localparam int CNT_W = 3;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/unified_mem_arbiter_lat_counter.sv
// Loadable down-counter that times one fixed-latency memory access.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (count -> 0)
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : starting count
//   done         : high while the count equals 1 (last cycle of the access)
module lat_counter
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_r;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r <= CNT_ZERO;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != CNT_ZERO) begin
         cnt_r <= cnt_r - CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == CNT_ONE);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch stage
// and the memory stage of the pipelined core. One access is in flight at a
// time; each takes MEM_LAT cycles after its mem_en strobe.
// Ports:
//   clk, reset_n             : clock, synchronous active-low reset
//   if_req/if_addr           : fetch request and PC
//   if_rdata/if_ready        : instruction word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata: load/store request from the M stage
//   d_rdata/d_ready          : load data (0 for stores), completion pulse
//   stall_if/stall_m         : pending-request stalls for the pipeline
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory interface
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 2
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          stall_if,
   output logic          stall_m,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(MEM_LAT);

   arb_state_t state_r;
   logic       last_grant_r;
   logic       store_r;
   logic       hold_r;
   logic       live_s;
   logic       grant_s;
   logic       winner_s;
   logic       cnt_done_s;
   logic       if_ready_s;
   logic       d_ready_s;

   // All outputs stay quiet in the reset cycle and in the cycle after it,
   // so a request held across reset is only served one cycle later.
   assign live_s = reset_n & ~hold_r;

   // Arbitration in IDLE: single requester wins; on a tie the requester
   // that did not win last time goes, so back-to-back loads cannot starve fetch.
   always_comb begin
      grant_s  = 1'b0;
      winner_s = GRANT_IF;
      if (live_s && (state_r == IDLE)) begin
         if (if_req && d_req) begin
            grant_s  = 1'b1;
            winner_s = ~last_grant_r;
         end else if (d_req) begin
            grant_s  = 1'b1;
            winner_s = GRANT_D;
         end else if (if_req) begin
            grant_s  = 1'b1;
            winner_s = GRANT_IF;
         end else begin
            grant_s  = 1'b0;
            winner_s = GRANT_IF;
         end
      end else begin
         grant_s  = 1'b0;
         winner_s = GRANT_IF;
      end
   end

   // Access timer: loaded on the grant cycle, done flags the completion cycle.
   lat_counter u_lat_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (grant_s),
      .load_val (LAT_VAL),
      .done     (cnt_done_s)
   );

   // FSM state, fairness flag, store flag and post-reset mute register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_D;
         store_r      <= 1'b0;
         hold_r       <= 1'b1;
      end else begin
         hold_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  state_r      <= (winner_s == GRANT_D) ? BUSY_D : BUSY_I;
                  last_grant_r <= winner_s;
                  store_r      <= (winner_s == GRANT_D) & d_we;
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY_I, BUSY_D: begin
               state_r <= cnt_done_s ? IDLE : state_r;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Memory strobe, completion pulses, read-data steering and stalls.
   always_comb begin
      if_ready_s = live_s & (state_r == BUSY_I) & cnt_done_s;
      d_ready_s  = live_s & (state_r == BUSY_D) & cnt_done_s;

      mem_en    = grant_s;
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
      if (grant_s && (winner_s == GRANT_D)) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (grant_s) begin
         mem_addr  = if_addr;
      end else begin
         mem_addr  = {AW{1'b0}};
      end

      if_ready = if_ready_s;
      d_ready  = d_ready_s;
      if_rdata = if_ready_s ? mem_rdata : {DW{1'b0}};
      // Stores return no data; keep the bus at zero for them.
      d_rdata  = (d_ready_s && !store_r) ? mem_rdata : {DW{1'b0}};

      stall_if = live_s & if_req & ~if_ready_s;
      stall_m  = live_s & d_req & ~d_ready_s;
   end

endmodule
